// File: rtl/uart_console_pkg.sv
// rtl/uart_console_pkg.sv - console protocol constants, state encoding and size helpers
package uart_console_pkg;

    localparam logic [7:0] ENQ = 8'h05;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] FRX = 8'h07;
    localparam logic [7:0] FTX = 8'h08;

    localparam logic [2:0] ST_CONNECT = 3'd0;
    localparam logic [2:0] ST_REPLY   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_TXSZ    = 3'd3;
    localparam logic [2:0] ST_TXF     = 3'd4;
    localparam logic [2:0] ST_RXSZ    = 3'd5;
    localparam logic [2:0] ST_RXF     = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    typedef enum logic [2:0] {
        S_CONNECT = ST_CONNECT,
        S_REPLY   = ST_REPLY,
        S_RUN     = ST_RUN,
        S_TXSZ    = ST_TXSZ,
        S_TXF     = ST_TXF,
        S_RXSZ    = ST_RXSZ,
        S_RXF     = ST_RXF,
        S_DONE    = ST_DONE
    } state_t;

    localparam int SIZE_W_DFLT = 32;
    localparam int SIZE_BYTES  = SIZE_W_DFLT / 8;

    function automatic int size_bytes(input int size_w);
        return size_w / 8;
    endfunction

endpackage

// File: rtl/console_char_fifo.sv
// rtl/console_char_fifo.sv - synchronous first-word-fall-through FIFO for console characters
module console_char_fifo #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign pop_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/uart_console_engine.sv
// rtl/uart_console_engine.sv - console handshake, file transfer and print buffering over a UART byte stream
import uart_console_pkg::*;

module uart_console_engine #(
    parameter int SIZE_W = SIZE_W_DFLT,
    parameter int PRN_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_fw,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [SIZE_W-1:0] src_size,
    input  logic [7:0]        src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [7:0]        snk_data,
    output logic              snk_valid,
    input  logic              snk_ready,
    output logic [SIZE_W-1:0] snk_size,
    output logic              snk_size_vld,
    output logic [7:0]        prn_data,
    output logic              prn_valid,
    input  logic              prn_ready,
    output logic              connected,
    output logic              done,
    output logic              prn_drop
);

    localparam int SB    = size_bytes(SIZE_W);
    localparam int IDX_W = (SB > 1) ? $clog2(SB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SB - 1);

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic [SIZE_W-1:0] snk_size_q, snk_size_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        reply_q, reply_d;
    logic              connected_q, connected_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              vld_q, vld_d;
    logic              push, pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_data;

    console_char_fifo #(
        .DATA_W (8),
        .AW     (PRN_AW)
    ) u_prn_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (rx_data),
        .pop_i       (prn_ready),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign pop = prn_ready && !fifo_empty;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        reply_d     = reply_q;
        connected_d = connected_q;
        done_d      = done_q;
        snk_size_d  = snk_size_q;
        vld_d       = 1'b0;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        src_ready   = 1'b0;
        snk_valid   = 1'b0;
        snk_data    = 8'h00;
        push        = 1'b0;

        // Handshake outputs stay low while reset is held so nothing moves mid-reset.
        if (rst) begin
            case (state_q)
                S_CONNECT, S_RUN: begin
                    rx_ready = 1'b1;
                    if (rx_valid) begin
                        case (rx_data)
                            ENQ: begin
                                if (state_q == S_CONNECT && !connected_q) begin
                                    connected_d = 1'b1;
                                    reply_d     = ld_fw ? FRX : ACK;
                                    state_d     = S_REPLY;
                                end
                            end
                            EOT: begin
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                            FRX: begin
                                cnt_d   = src_size;
                                idx_d   = '0;
                                state_d = S_TXSZ;
                            end
                            FTX: begin
                                cnt_d   = '0;
                                idx_d   = '0;
                                state_d = S_RXSZ;
                            end
                            default: push = 1'b1;
                        endcase
                    end
                end
                S_REPLY: begin
                    tx_valid = 1'b1;
                    tx_data  = reply_q;
                    if (tx_ready) state_d = S_RUN;
                end
                S_TXSZ: begin
                    tx_valid = 1'b1;
                    tx_data  = 8'(cnt_q >> {idx_q, 3'b000});
                    if (tx_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = (cnt_q == '0) ? S_RUN : S_TXF;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                S_TXF: begin
                    tx_valid  = src_valid;
                    tx_data   = src_data;
                    src_ready = tx_ready;
                    if (src_valid && tx_ready) begin
                        cnt_d = cnt_q - SIZE_W'(1);
                        if (cnt_q == SIZE_W'(1)) state_d = S_RUN;
                    end
                end
                S_RXSZ: begin
                    rx_ready = 1'b1;
                    if (rx_valid) begin
                        cnt_d = cnt_q | (SIZE_W'(rx_data) << {idx_q, 3'b000});
                        if (idx_q == LAST_IDX) begin
                            idx_d      = '0;
                            snk_size_d = cnt_d;
                            vld_d      = 1'b1;
                            state_d    = (cnt_d == '0) ? S_RUN : S_RXF;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                S_RXF: begin
                    rx_ready  = snk_ready;
                    snk_valid = rx_valid;
                    snk_data  = rx_data;
                    if (rx_valid && snk_ready) begin
                        cnt_d = cnt_q - SIZE_W'(1);
                        if (cnt_q == SIZE_W'(1)) state_d = S_RUN;
                    end
                end
                S_DONE: begin
                end
                default: state_d = S_CONNECT;
            endcase
        end

        drop_d = drop_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_CONNECT;
            cnt_q       <= '0;
            idx_q       <= '0;
            reply_q     <= 8'h00;
            connected_q <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            vld_q       <= 1'b0;
            snk_size_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            reply_q     <= reply_d;
            connected_q <= connected_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            vld_q       <= vld_d;
            snk_size_q  <= snk_size_d;
        end
    end

    assign snk_size     = snk_size_q;
    assign snk_size_vld = vld_q;
    assign prn_data     = fifo_data;
    assign prn_valid    = !fifo_empty;
    assign connected    = connected_q;
    assign done         = done_q;
    assign prn_drop     = drop_q;

endmodule

// File: doc/uart_console_engine.md
Name: uart_console_engine

Overview:
- Synthesizable console-protocol engine that sits between an iob_uart byte stream and host-side consumers.
- Implements the boot/console handshake:
  - ENQ connect, answered once with ACK or FRX;
  - file send (FRX) and file receive (FTX) with a little-endian size header;
  - EOT termination;
  - buffered forwarding of printable characters.
- Generalises the simulation-only console loop to hardware, with a parametrised size-header width, print-buffer depth and runtime load-firmware mode.

Parameters:
- SIZE_W, 32, file-size header width in bits; multiple of 8; header is SIZE_W/8 bytes, LSB first.
- PRN_AW, 4, log2 depth of the print FIFO (16 entries).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- ld_fw  in  1  1: answer first ENQ with FRX; 0: answer with ACK. Sampled in S_CONNECT.
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid&rx_ready
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts
- src_size  in  SIZE_W  length of file to send; sampled on FRX acceptance
- src_data  in  8  outgoing file byte
- src_valid  in  1  outgoing byte valid
- src_ready  out  1  outgoing byte consumed
- snk_data  out  8  incoming file byte
- snk_valid  out  1  incoming byte valid
- snk_ready  in  1  consumer accepts
- snk_size  out  SIZE_W  received file length; held until next FTX
- snk_size_vld  out  1  1-cycle pulse when header complete
- prn_data  out  8  console character
- prn_valid  out  1  print FIFO non-empty
- prn_ready  in  1  pop print FIFO
- connected  out  1  first ENQ handled
- done  out  1  EOT received; sticky until reset
- prn_drop  out  1  sticky: character dropped on full FIFO

Behaviour:
- Reset (rst==0 at posedge clk):
  - All outputs 0; state S_CONNECT; FIFO empty; counters 0.
  - Reset mid-transfer aborts it with no further tx/snk activity.
- Control bytes: ENQ=8'h05, EOT=8'h04, ACK=8'h06, FRX=8'h07, FTX=8'h08.
- All streams use valid/ready handshakes.
  - Outputs hold data stable while valid is high and not accepted.
  - Maximum one byte per stream per cycle.
- States:
  - S_CONNECT: rx_ready=1.
    - ENQ, first time: set connected, go to S_REPLY.
    - ENQ after connected: ignored.
    - Other bytes: handled as in S_RUN.
  - S_REPLY: tx_data = ld_fw ? FRX : ACK, tx_valid=1. On accept go to S_RUN.
  - S_RUN: rx_ready=1.
    - EOT: set done, go to S_DONE.
    - FRX: latch src_size into cnt, go to S_TXSZ.
    - FTX: cnt=0, go to S_RXSZ.
    - ENQ: ignored.
    - Any other byte: pushed into the print FIFO.
  - S_TXSZ: emit SIZE_W/8 bytes of the latched size, LSB first, via tx. Then go to S_TXF, or to S_RUN if the size is 0.
  - S_TXF: pass src_data to tx combinationally (tx_valid=src_valid, src_ready=tx_ready). Decrement cnt per accepted byte; go to S_RUN when cnt reaches 0.
  - S_RXSZ: accept SIZE_W/8 rx bytes, assembling LSB first.
    - After the last byte: snk_size updated, snk_size_vld pulses next cycle.
    - Then go to S_RXF, or to S_RUN if the size is 0.
  - S_RXF: pass rx to snk (rx_ready=snk_ready). Decrement per byte; go to S_RUN at 0.
  - S_DONE: rx_ready=0, tx_valid=0. Terminal until reset.
- Control bytes inside S_TXF, S_RXSZ and S_RXF payload/header are data, not commands.
- Print FIFO behaviour:
  - Push is not back-pressured, so rx never stalls on console traffic.
  - Push while full: byte dropped, prn_drop set.
  - Simultaneous push and pop while full: the pop frees space, the push succeeds, no drop.
  - prn_valid = !empty (first-word-fall-through).
  - Pointers are PRN_AW+1 bits with wrap-around.
- Latency:
  - rx byte to prn_valid: 1 cycle.
  - ENQ accepted to tx_valid (S_REPLY): 1 cycle.
  - FRX accepted to first header byte: 1 cycle.
- cnt is SIZE_W bits; a maximum size of 2^SIZE_W-1 is legal.

Decomposition:
- Package uart_console_pkg holds:
  - control-byte constants;
  - state encoding (3-bit localparams);
  - SIZE_BYTES = SIZE_W/8.
- One sub-module, console_char_fifo: parametrised sync FWFT FIFO (DATA_W=8, AW=PRN_AW) exposing full/empty, used for the print path.

Test Plan:
- Reset, ld_fw=0, rx sequence 05,05,05 -> exactly one tx byte 06; connected=1 after the first 05; prn_valid stays 0.
- ld_fw=1, rx 05 -> tx 07; then rx 07 with src_size=3 and src bytes AA,BB,CC -> tx 03,00,00,00,AA,BB,CC; return to S_RUN.
- Connected, rx 08,02,00,00,00,04,05 -> snk_size=2, snk_size_vld 1-cycle pulse, snk bytes 04,05 (no EOT/ENQ action); then rx 04 -> done=1, rx_ready=0.
- prn_ready=0, rx 17 printable bytes 41..51 -> FIFO holds 41..50, prn_drop=1; pop yields 41..50 in order.
- tx_ready held 0 for 5 cycles during the header -> tx_data/tx_valid stable; no byte skipped.
- Assert rst=0 mid S_RXF after 1 of 4 bytes -> next cycle all outputs 0, state S_CONNECT; a fresh 05 gives ACK.
